lead_count: RTL and testbench
=============================

LEAD_COUNT -- requirements
Module: lead_count

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high, and the ports SHALL be named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 A  input  32  operand to scan.
REQ-005 Op  input  1  0 = count leading zeros (CLZ), 1 = count leading ones (CLO).
REQ-006 in_valid  input  1  A and Op are valid.
REQ-007 in_ready  output  1  block can accept an operand.
REQ-008 Result  output  32  leading count, 0..32, zero-extended.
REQ-009 Normalized  output  32  A shifted left logically by Result; 0 when Result = 32.
REQ-010 out_valid  output  1  Result and Normalized are valid.
REQ-011 out_ready  input  1  consumer accepts the result.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-014 Acceptance SHALL occur on a rising edge with in_valid=1 in IDLE; on acceptance the block SHALL latch A and Op, clear the count, and enter SCAN.
REQ-015 A and Op SHALL be ignored outside acceptance; latched values SHALL NOT change during SCAN or DONE.
REQ-016 For CLO, the block SHALL scan the bitwise inverse of the latched A; for CLZ, the latched A unchanged.
REQ-017 SCAN SHALL examine one 4-bit nibble per cycle, MSB nibble first (bits 31:28, then 27:24, and so on).
REQ-018 On a scanned nibble that contains a 1, the block SHALL add that nibble's leading-zero count (0..3) to the count and enter DONE.
REQ-019 On an all-zero nibble, the block SHALL add 4 to the count.
REQ-019a If the all-zero nibble is bits 3:0, the block SHALL enter DONE with count 32.
REQ-020 Latency from the acceptance edge to out_valid=1 SHALL be k+1 cycles, where k is the index of the first nibble containing a 1 (0..7); an all-zero scanned word SHALL take 8 cycles.
REQ-021 Normalized SHALL be built by shifting the latched A left 4 per skipped nibble, then by the final in-nibble count; arithmetic SHALL use the original A, not the inverse.
REQ-022 Result and Normalized SHALL be registered and held stable while out_valid=1.
REQ-023 DONE SHALL persist until out_valid and out_ready are both 1 on an edge; the block SHALL then enter IDLE, so in_ready=1 in the next cycle.
REQ-024 The block SHALL NOT accept a new operand in the same cycle as the output handshake; throughput SHALL be at most one operation per latency + 2 cycles.
REQ-025 Result and Normalized SHALL keep the last values after the handshake until the next DONE.

Reset
REQ-026 While rst=1, the block SHALL force state IDLE, count 0, Result 0, Normalized 0, and out_valid 0, immediately without waiting for clk; in_ready SHALL be 1.
REQ-027 Reset asserted in SCAN or DONE SHALL abort the operation with no out_valid pulse, and no stale result SHALL appear after release.
REQ-028 After rst deasserts, the first acceptance SHALL be possible on the first rising edge.

Configuration
REQ-029 Macro LEAD_COUNT_FAST_EN, when defined, SHALL replace the nibble iteration with a single-cycle 32-bit priority encoder: SCAN lasts exactly one cycle, and latency is 1 for every operand.
REQ-030 Without LEAD_COUNT_FAST_EN, the block SHALL use the nibble-serial behaviour of REQ-017..REQ-020.
REQ-031 In both builds, the values of Result and Normalized, the handshake rules, and the reset behaviour SHALL be identical.

Verification
REQ-032 A=0x0000_1000, Op=0 -> Result=19, Normalized=0x8000_0000, out_valid 5 cycles after acceptance (1 with FAST_EN).
REQ-033 A=0x0000_0000, Op=0 -> Result=32, Normalized=0, latency 8; then A=0xFFFF_FFFF, Op=1 -> Result=32, latency 8.
REQ-034 A=0xF0F0_0000, Op=1 -> Result=4, Normalized=0x0F00_0000, latency 2; A=0x8000_0000, Op=0 -> Result=0, Normalized=0x8000_0000, latency 1.
REQ-035 Backpressure: out_ready=0 for 3 cycles in DONE -> out_valid, Result and Normalized held, in_ready=0; at the out_ready=1 edge, in_ready=1 next cycle; in_valid pulses during the stall are ignored.
REQ-036 rst pulsed mid-SCAN on A=0x0000_0001 -> out_valid=0 and in_ready=1 asynchronously, with no DONE afterward; next operand A=0x0001_0000, Op=0 -> Result=15.

Source files
------------

// File: rtl/lead_count.sv
// Leading-zero / leading-one counter with a valid/ready handshake on both sides.
// Define LEAD_COUNT_FAST_EN for the single-cycle priority-encoder build; the default is nibble-serial.
module lead_count (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic        Op,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] Result,
    output logic [31:0] Normalized,
    output logic        out_valid,
    input  logic        out_ready
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
    // in_ready is high only in IDLE and out_valid only in DONE, so the two never overlap.
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] a_reg;
    logic        op_reg;
    logic [31:0] scan_word;
    logic [5:0]  fin_count;
    logic [31:0] fin_norm;
    logic        step_done;

`ifdef LEAD_COUNT_FAST_EN
    // Highest set bit wins because later loop iterations overwrite earlier ones.
    always_comb begin
        scan_word = op_reg ? ~a_reg : a_reg;
        fin_count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (scan_word[i]) fin_count = 6'(31 - i);
        end
        fin_norm  = (fin_count == 6'd32) ? 32'd0 : (a_reg << fin_count[4:0]);
        step_done = 1'b1;
    end
`else
    logic [2:0]  idx;
    logic [5:0]  count;
    logic [31:0] shifted_a;
    logic [3:0]  nibble;
    logic [1:0]  nib_lz;

    // Nibble idx sits at bit offset 4*(7-idx), i.e. {~idx, 2'b00}.
    always_comb begin
        scan_word = op_reg ? ~a_reg : a_reg;
        nibble    = scan_word[{~idx, 2'b00} +: 4];
        shifted_a = a_reg << {idx, 2'b00};
        nib_lz    = 2'd3;
        if (nibble[3])      nib_lz = 2'd0;
        else if (nibble[2]) nib_lz = 2'd1;
        else if (nibble[1]) nib_lz = 2'd2;
        step_done = (nibble != 4'd0) || (idx == 3'd7);
        if (nibble != 4'd0) begin
            fin_count = count + {4'd0, nib_lz};
            fin_norm  = shifted_a << nib_lz;
        end else begin
            fin_count = count + 6'd4;
            fin_norm  = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= 3'd0;
            count <= 6'd0;
        end else if (state == IDLE && in_valid) begin
            idx   <= 3'd0;
            count <= 6'd0;
        end else if (state == SCAN) begin
            idx   <= idx + 3'd1;
            count <= count + 6'd4;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = SCAN;
            end
            SCAN: begin
                if (step_done) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Results only change on entry to DONE, so they hold through and after the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= 32'd0;
            op_reg     <= 1'b0;
            Result     <= 32'd0;
            Normalized <= 32'd0;
        end else if (state == IDLE && in_valid) begin
            a_reg  <= A;
            op_reg <= Op;
        end else if (state == SCAN && step_done) begin
            Result     <= {26'd0, fin_count};
            Normalized <= fin_norm;
        end
    end

endmodule

// File: tb/tb_lead_count.sv
// Self-checking bench for lead_count: directed vectors, random operands, backpressure and mid-scan reset.
module tb_lead_count;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A;
    logic        Op;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Result;
    logic [31:0] Normalized;
    logic        out_valid;
    logic        out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_res_q[$];
    logic [31:0] exp_norm_q[$];
    int          exp_lat_q[$];

    always #5 clk = ~clk;

    lead_count dut (
        .clk(clk), .rst(rst), .A(A), .Op(Op), .in_valid(in_valid), .in_ready(in_ready),
        .Result(Result), .Normalized(Normalized), .out_valid(out_valid), .out_ready(out_ready)
    );

    function automatic int model_count(input logic [31:0] a, input logic op);
        logic [31:0] v;
        int c;
        v = op ? ~a : a;
        c = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) break;
            c++;
        end
        return c;
    endfunction

    task automatic push_expect(input logic [31:0] a, input logic op);
        int c;
        int lat;
        c = model_count(a, op);
`ifdef LEAD_COUNT_FAST_EN
        lat = 1;
`else
        lat = (c == 32) ? 8 : (c / 4 + 1);
`endif
        exp_res_q.push_back(32'(c));
        exp_norm_q.push_back((c == 32) ? 32'd0 : (a << c));
        exp_lat_q.push_back(lat);
    endtask

    task automatic send(input logic [31:0] a, input logic op);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_in_ready: got %b want 1", in_ready);
        end
        A = a;
        Op = op;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = $urandom;
        Op = 1'($urandom_range(0, 1));
        push_expect(a, op);
    endtask

    task automatic wait_result();
        int lat;
        logic [31:0] er, en;
        int el;
        lat = 0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_in_ready: got %b want 0", in_ready);
        end
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        er = exp_res_q.pop_front();
        en = exp_norm_q.pop_front();
        el = exp_lat_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL out_valid_timeout: got %b want 1 within 40 cycles", out_valid);
        end
        n_cmp++;
        if (lat != el) begin
            n_bad++;
            $display("FAIL latency: got %0d want %0d", lat, el);
        end
        n_cmp++;
        if (Result !== er) begin
            n_bad++;
            $display("FAIL result: got %0d want %0d", Result, er);
        end
        n_cmp++;
        if (Normalized !== en) begin
            n_bad++;
            $display("FAIL normalized: got %h want %h", Normalized, en);
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL after_handshake: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic op);
        send(a, op);
        wait_result();
        finish_op();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        A = 32'd0;
        Op = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_handshake: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        n_cmp++;
        if (Result !== 32'd0 || Normalized !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h/%h want 0/0", Result, Normalized);
        end
        rst = 1'b0;
        // first edge after release must accept
        run_op(32'h8000_0000, 1'b0);
    endtask

    task automatic test_vectors();
        run_op(32'h0000_1000, 1'b0);
        run_op(32'h0000_0000, 1'b0);
        run_op(32'hFFFF_FFFF, 1'b1);
        run_op(32'hF0F0_0000, 1'b1);
        run_op(32'h8000_0000, 1'b0);
        run_op(32'h7FFF_FFFF, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic op;
        for (int i = 0; i < 12; i++) begin
            a = $urandom >> $urandom_range(0, 31);
            op = 1'($urandom_range(0, 1));
            if (op) a = ~a;
            run_op(a, op);
        end
    endtask

    task automatic test_backpressure();
        send(32'h0000_1000, 1'b0);
        wait_result();
        for (int i = 0; i < 3; i++) begin
            A = $urandom;
            in_valid = 1'b1;
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || Result !== 32'd19 || Normalized !== 32'h8000_0000) begin
                n_bad++;
                $display("FAIL stall_hold: got ov=%b ir=%b res=%0d norm=%h want 1/0/19/80000000",
                         out_valid, in_ready, Result, Normalized);
            end
        end
        // in_valid stays high across the handshake edge; it must not be taken there
        A = 32'h1234_5678;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL handshake_no_accept: got ir=%b ov=%b want 1/0", in_ready, out_valid);
        end
        n_cmp++;
        if (Result !== 32'd19 || Normalized !== 32'h8000_0000) begin
            n_bad++;
            $display("FAIL result_kept: got %0d/%h want 19/80000000", Result, Normalized);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_stays: got ir=%b ov=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic seen;
        send(32'h0000_0001, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_handshake: got ir=%b ov=%b want 1/0", in_ready, out_valid);
        end
        n_cmp++;
        if (Result !== 32'd0 || Normalized !== 32'd0) begin
            n_bad++;
            $display("FAIL async_reset_outputs: got %h/%h want 0/0", Result, Normalized);
        end
        rst = 1'b0;
        void'(exp_res_q.pop_back());
        void'(exp_norm_q.pop_back());
        void'(exp_lat_q.pop_back());
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL no_stale_done: got out_valid pulse want none");
        end
        run_op(32'h0001_0000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
